nn_dense_engine: RTL and testbench

- Fully-connected neural-network layer compute engine sitting directly downstream of the Wishbone slave block `wishbone_nn`.
- The slave's register decoder writes weights and inputs into this engine, pulses `start`, waits for `done`, then reads back the outputs.
- Computes y[j] = act(sat((sum_i W[j][i]*x[i]) >>> SHIFT)) with one serial signed MAC per cycle.

---
 rtl/nn_pkg.sv | 34 +++
 rtl/nn_dense_engine_mac.sv | 29 ++
 rtl/nn_dense_engine.sv | 129 ++++++++++++
 tb/tb_nn_dense_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer engine and its Wishbone front end.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_STORE,
    ST_DONE
  } nn_state_e;

  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 20;

  localparam logic signed [ACC_W_DEF-1:0] SAT_MAX = ACC_W_DEF'((2 ** (DW_DEF - 1)) - 1);
  localparam logic signed [ACC_W_DEF-1:0] SAT_MIN = -SAT_MAX - 1;

  function automatic logic signed [DW_DEF-1:0] sat_dw(input logic signed [ACC_W_DEF-1:0] a);
    logic signed [DW_DEF-1:0] r;
    if (a > SAT_MAX) begin
      r = SAT_MAX[DW_DEF-1:0];
    end else if (a < SAT_MIN) begin
      r = SAT_MIN[DW_DEF-1:0];
    end else begin
      r = a[DW_DEF-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [DW_DEF-1:0] relu_dw(input logic signed [DW_DEF-1:0] v,
                                                       input logic en);
    return (en && v[DW_DEF-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/nn_dense_engine_mac.sv
// Serial signed multiply-accumulate: one DW x DW product folded into the accumulator per enable.
module nn_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q;

  assign prod  = a_i * b_i;
  assign acc_o = acc_q;

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/nn_dense_engine.sv
// Fully-connected layer engine: y[j] = act(sat((sum_i W[j][i]*x[i]) >>> SHIFT)),
// one MAC per cycle, weights/inputs loadable only while idle.
module nn_dense_engine
  import nn_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = 4
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             w_we,
  input  logic [$clog2(N_OUT*N_IN)-1:0]    w_addr,
  input  logic [DW-1:0]                    w_data,
  input  logic                             x_we,
  input  logic [$clog2(N_IN)-1:0]          x_addr,
  input  logic [DW-1:0]                    x_data,
  input  logic                             relu_en,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic [$clog2(N_OUT)-1:0]         y_addr,
  output logic [DW-1:0]                    y_data
);

  localparam int N_W = N_OUT * N_IN;
  localparam int WAW = $clog2(N_W);
  localparam int IW  = $clog2(N_IN);
  localparam int JW  = $clog2(N_OUT);

  nn_state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic          relu_q, relu_d;
  logic          mac_en, mac_clr;

  logic signed [DW-1:0]    w_q [N_W];
  logic signed [DW-1:0]    x_q [N_IN];
  logic signed [DW-1:0]    y_q [N_OUT];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [DW-1:0]    y_new;
  logic [WAW-1:0]          w_idx;
  logic                    idle;

  assign w_idx  = WAW'(int'(j_q) * N_IN + int'(i_q));
  assign idle   = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_MAC) || (state_q == ST_STORE);
  assign done   = (state_q == ST_DONE);
  assign acc_sh = acc >>> SHIFT;
  assign y_new  = relu_dw(sat_dw(acc_sh), relu_q);
  assign y_data = y_q[y_addr];

  nn_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i  (wb_clk_i),
    .srst_i (wb_rst_i),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (w_q[w_idx]),
    .b_i    (x_q[i_q]),
    .acc_o  (acc)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    relu_d  = relu_q;
    mac_en  = 1'b0;
    mac_clr = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MAC;
          i_d     = '0;
          j_d     = '0;
          relu_d  = relu_en;
        end
      end
      ST_MAC: begin
        mac_en  = 1'b1;
        mac_clr = 1'b0;
        if (i_q == IW'(N_IN - 1)) begin
          state_d = ST_STORE;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_STORE: begin
        // The accumulator clears on this edge so the next neuron starts from zero.
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      relu_q  <= 1'b0;
      for (int k = 0; k < N_W; k++)   w_q[k] <= '0;
      for (int k = 0; k < N_IN; k++)  x_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      relu_q  <= relu_d;
      if (idle && w_we && (int'(w_addr) < N_W)) w_q[w_addr] <= w_data;
      if (idle && x_we && (int'(x_addr) < N_IN)) x_q[x_addr] <= x_data;
      if (state_q == ST_STORE) y_q[j_q] <= y_new;
    end
  end

endmodule

// File: tb/tb_nn_dense_engine.sv
// Directed bench: two engines (SHIFT=0 and SHIFT=4) share stimulus; results checked against hand-computed values.
module tb_nn_dense_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_we;
  logic [4:0] w_addr;
  logic [7:0] w_data;
  logic       x_we;
  logic [2:0] x_addr;
  logic [7:0] x_data;
  logic       relu_en;
  logic       start;
  logic [1:0] y_addr;
  logic       busy0, done0, busy4, done4;
  logic signed [7:0] y0, y4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nn_dense_engine #(.SHIFT(0)) d0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
    .relu_en(relu_en), .start(start), .busy(busy0), .done(done0),
    .y_addr(y_addr), .y_data(y0)
  );

  nn_dense_engine #(.SHIFT(4)) d4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
    .relu_en(relu_en), .start(start), .busy(busy4), .done(done4),
    .y_addr(y_addr), .y_data(y4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag,
                       input int a0, input int a1, input int a2, input int a3,
                       input int b0, input int b1, input int b2, input int b3);
    int ea [4];
    int eb [4];
    ea = '{a0, a1, a2, a3};
    eb = '{b0, b1, b2, b3};
    for (int a = 0; a < 4; a++) begin
      y_addr = 2'(a);
      #1;
      chk($sformatf("%s.s0.y%0d", tag, a), y0, ea[a]);
      chk($sformatf("%s.s4.y%0d", tag, a), y4, eb[a]);
      $display("%s y[%0d]: shift0=%0d shift4=%0d", tag, a, y0, y4);
    end
  endtask

  // mode 0: every weight = v; mode 1: row j weights = j+1
  task automatic load_w(input int mode, input int v);
    for (int a = 0; a < 32; a++) begin
      w_we = 1'b1; w_addr = 5'(a);
      w_data = (mode == 1) ? 8'(a / 8 + 1) : 8'(v);
      tick();
    end
    w_we = 1'b0;
  endtask

  // mode 0: every input = v; mode 1: x[i] = i+1
  task automatic load_x(input int mode, input int v);
    for (int i = 0; i < 8; i++) begin
      x_we = 1'b1; x_addr = 3'(i);
      x_data = (mode == 1) ? 8'(i + 1) : 8'(v);
      tick();
    end
    x_we = 1'b0;
  endtask

  // Runs one layer; optionally re-pulses start / writes weight 0 / asserts reset at busy cycle n.
  task automatic run(input string tag, input int again_at, input int we_at, input int rst_at);
    int n;
    int dn;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_on"}, busy0, 1);
    n = 0;
    dn = 0;
    while (busy0 && n < 100) begin
      if (n == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, ".rst_busy"}, busy0, 0);
        chk({tag, ".rst_done"}, done0, 0);
        tick();
        chk({tag, ".rst_nodone"}, done0, 0);
        $display("%s: reset at busy cycle %0d", tag, n);
        return;
      end
      start  = (n == again_at);
      w_we   = (n == we_at);
      w_addr = 5'd0;
      w_data = 8'd99;
      if (done0 || done4) dn++;
      n++;
      tick();
    end
    start = 1'b0;
    w_we  = 1'b0;
    chk({tag, ".busy_cycles"}, n, 36);
    chk({tag, ".busy4_off"}, busy4, 0);
    chk({tag, ".done0"}, done0, 1);
    chk({tag, ".done4"}, done4, 1);
    chk({tag, ".early_done"}, dn, 0);
    tick();
    chk({tag, ".done_pulse"}, done0, 0);
    $display("%s: busy %0d cycles, done pulse seen", tag, n);
  endtask

  initial begin
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    x_we = 1'b0; x_addr = '0; x_data = '0;
    relu_en = 1'b0; start = 1'b0; y_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset.busy", busy0, 0);
    chk("reset.done", done0, 0);
    chk_y("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    load_w(0, 1); load_x(1, 0);
    run("ones", -1, -1, -1);
    chk_y("ones", 36, 36, 36, 36, 2, 2, 2, 2);

    load_w(0, -1);
    run("neg", -1, -1, -1);
    chk_y("neg", -36, -36, -36, -36, -3, -3, -3, -3);
    relu_en = 1'b1;
    run("neg_relu", -1, -1, -1);
    chk_y("neg_relu", 0, 0, 0, 0, 0, 0, 0, 0);
    relu_en = 1'b0;

    load_w(0, 127); load_x(0, 127);
    run("satpos", -1, -1, -1);
    chk_y("satpos", 127, 127, 127, 127, 127, 127, 127, 127);
    load_w(0, -128);
    run("satneg", -1, -1, -1);
    chk_y("satneg", -128, -128, -128, -128, -128, -128, -128, -128);

    load_w(1, 0); load_x(0, 2);
    run("interfere", 10, 15, -1);
    chk_y("interfere", 16, 32, 48, 64, 1, 2, 3, 4);
    run("rerun", -1, -1, -1);
    chk_y("rerun", 16, 32, 48, 64, 1, 2, 3, 4);

    run("abort", -1, -1, 20);
    chk_y("abort", 0, 0, 0, 0, 0, 0, 0, 0);
    load_w(1, 0); load_x(0, 2);
    run("reload", -1, -1, -1);
    chk_y("reload", 16, 32, 48, 64, 1, 2, 3, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
